// File: rtl/led_seq_ctrl.sv
// LED switch-pattern sequencer: steps through a fixed 4-entry switch table,
// dwelling DWELL ticks of TICK_LIMIT clocks per step, with hold and manual step.
module led_seq_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int TICK_LIMIT = 50,
    parameter int DWELL      = 4
) (
    input  logic       clock,
    input  logic       i_reset,
    input  logic       i_enable,
    input  logic       i_hold,
    input  logic       i_step,
    output logic [3:0] o_sw,
    output logic [1:0] o_step_idx,
    output logic       o_cfg_valid,
    output logic       o_busy
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_HOLD = 2'b10;

    localparam int DWELL_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [DATA_WIDTH-1:0] PRESC_LAST = DATA_WIDTH'(TICK_LIMIT - 1);
    localparam logic [DWELL_W-1:0]    DWELL_LAST = DWELL_W'(DWELL - 1);

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] presc_q, presc_d;
    logic [DWELL_W-1:0]    dwell_q, dwell_d;
    logic [3:0]            sw_q, sw_d;
    logic [1:0]            step_idx_q, step_idx_d;
    logic                  cfg_valid_q, cfg_valid_d;
    logic                  busy_q, busy_d;

    logic                  tick;
    logic                  dwell_expire;
    logic [1:0]            next_idx;

    function automatic logic [3:0] step_pattern(input logic [1:0] idx);
        logic [3:0] pat;
        case (idx)
            2'd0:    pat = 4'b1001;
            2'd1:    pat = 4'b0001;
            2'd2:    pat = 4'b0011;
            default: pat = 4'b0101;
        endcase
        return pat;
    endfunction

    assign tick         = (presc_q == PRESC_LAST);
    assign dwell_expire = tick && (dwell_q == DWELL_LAST);
    assign next_idx     = step_idx_q + 2'd1;

    // Any edge that samples i_hold=1 freezes progress, whether it enters or stays in HOLD;
    // an edge in HOLD with i_hold=0 counts exactly like a RUN edge.
    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        dwell_d     = dwell_q;
        sw_d        = sw_q;
        step_idx_d  = step_idx_q;
        cfg_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                presc_d    = '0;
                dwell_d    = '0;
                sw_d       = 4'b0000;
                step_idx_d = 2'd0;
                if (i_enable) begin
                    state_d     = ST_RUN;
                    sw_d        = step_pattern(2'd0);
                    cfg_valid_d = 1'b1;
                end
            end

            ST_RUN, ST_HOLD: begin
                if (!i_enable) begin
                    state_d    = ST_IDLE;
                    presc_d    = '0;
                    dwell_d    = '0;
                    sw_d       = 4'b0000;
                    step_idx_d = 2'd0;
                end else if (i_hold) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_RUN;
                    if (i_step || dwell_expire) begin
                        // A manual step landing on a dwell expiry still yields one advance.
                        presc_d     = '0;
                        dwell_d     = '0;
                        step_idx_d  = next_idx;
                        sw_d        = step_pattern(next_idx);
                        cfg_valid_d = 1'b1;
                    end else if (tick) begin
                        presc_d = '0;
                        dwell_d = dwell_q + DWELL_W'(1);
                    end else begin
                        presc_d = presc_q + DATA_WIDTH'(1);
                    end
                end
            end

            default: begin
                state_d    = ST_IDLE;
                presc_d    = '0;
                dwell_d    = '0;
                sw_d       = 4'b0000;
                step_idx_d = 2'd0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= ST_IDLE;
            presc_q     <= '0;
            dwell_q     <= '0;
            sw_q        <= 4'b0000;
            step_idx_q  <= 2'd0;
            cfg_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            dwell_q     <= dwell_d;
            sw_q        <= sw_d;
            step_idx_q  <= step_idx_d;
            cfg_valid_q <= cfg_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign o_sw        = sw_q;
    assign o_step_idx  = step_idx_q;
    assign o_cfg_valid = cfg_valid_q;
    assign o_busy      = busy_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Scoreboard bench for led_seq_ctrl: expected step loads are queued by the
// stimulus and matched against every o_cfg_valid pulse by a separate monitor.
module tb_led_seq_ctrl;

    logic       clock = 1'b0;
    logic       i_reset;
    logic       i_enable, i_hold, i_step;
    logic [3:0] o_sw;
    logic [1:0] o_step_idx;
    logic       o_cfg_valid, o_busy;

    logic       f_enable;
    logic [3:0] f_sw;
    logic [1:0] f_idx;
    logic       f_valid, f_busy;

    int cyc = 0;
    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0] sw;
        logic [1:0] idx;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    led_seq_ctrl #(.DATA_WIDTH(32), .TICK_LIMIT(3), .DWELL(2)) u_dut (
        .clock      (clock),
        .i_reset    (i_reset),
        .i_enable   (i_enable),
        .i_hold     (i_hold),
        .i_step     (i_step),
        .o_sw       (o_sw),
        .o_step_idx (o_step_idx),
        .o_cfg_valid(o_cfg_valid),
        .o_busy     (o_busy)
    );

    led_seq_ctrl #(.DATA_WIDTH(8), .TICK_LIMIT(1), .DWELL(1)) u_dut_fast (
        .clock      (clock),
        .i_reset    (i_reset),
        .i_enable   (f_enable),
        .i_hold     (1'b0),
        .i_step     (1'b0),
        .o_sw       (f_sw),
        .o_step_idx (f_idx),
        .o_cfg_valid(f_valid),
        .o_busy     (f_busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic push(input logic [3:0] sw, input logic [1:0] idx, input int c);
        exp_t e;
        e.sw  = sw;
        e.idx = idx;
        e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clock);
    endtask

    // Monitor: every load pulse must match the oldest queued expectation.
    always @(negedge clock) begin
        if (o_cfg_valid === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_load: got sw=%b idx=%0d at cycle %0d, expected no load",
                         o_sw, o_step_idx, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (o_sw !== mon_e.sw || o_step_idx !== mon_e.idx || cyc != mon_e.cyc) begin
                    n_fail++;
                    $display("FAIL step_load: got sw=%b idx=%0d cycle=%0d, expected sw=%b idx=%0d cycle=%0d",
                             o_sw, o_step_idx, cyc, mon_e.sw, mon_e.idx, mon_e.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0, l, m, n, p, r, f;
        logic [3:0] fast_sw [5];
        fast_sw[0] = 4'b1001;
        fast_sw[1] = 4'b0001;
        fast_sw[2] = 4'b0011;
        fast_sw[3] = 4'b0101;
        fast_sw[4] = 4'b1001;

        i_reset  = 1'b0;
        i_enable = 1'b0;
        i_hold   = 1'b0;
        i_step   = 1'b0;
        f_enable = 1'b0;

        repeat (3) @(negedge clock);
        check("rst_sw",    int'(o_sw), 0);
        check("rst_idx",   int'(o_step_idx), 0);
        check("rst_valid", int'(o_cfg_valid), 0);
        check("rst_busy",  int'(o_busy), 0);
        i_reset = 1'b1;

        repeat (2) @(negedge clock);
        check("idle_busy", int'(o_busy), 0);
        check("idle_sw",   int'(o_sw), 0);

        // Enable and free run: one load every 6 cycles, wrapping 3 -> 0.
        c0 = cyc;
        i_enable = 1'b1;
        push(4'b1001, 2'd0, c0 + 1);
        push(4'b0001, 2'd1, c0 + 7);
        push(4'b0011, 2'd2, c0 + 13);
        push(4'b0101, 2'd3, c0 + 19);
        push(4'b1001, 2'd0, c0 + 25);
        wait_to(c0 + 1);
        check("run_busy", int'(o_busy), 1);

        // Hold for 10 edges two cycles into a step; 4 counting edges remain afterwards.
        l = c0 + 25;
        wait_to(l + 2);
        i_hold = 1'b1;
        push(4'b0001, 2'd1, l + 16);
        wait_to(l + 7);
        check("hold_sw",   int'(o_sw), 9);
        check("hold_idx",  int'(o_step_idx), 0);
        check("hold_busy", int'(o_busy), 1);
        wait_to(l + 12);
        check("hold_sw_end", int'(o_sw), 9);
        i_hold = 1'b0;

        // Manual step two cycles after a load, then a step on a dwell-expiry tick.
        m = l + 16;
        wait_to(m + 2);
        i_step = 1'b1;
        push(4'b0011, 2'd2, m + 3);
        wait_to(m + 3);
        i_step = 1'b0;
        push(4'b0101, 2'd3, m + 9);
        push(4'b1001, 2'd0, m + 15);
        push(4'b0001, 2'd1, m + 21);
        wait_to(m + 14);
        i_step = 1'b1;
        wait_to(m + 15);
        i_step = 1'b0;
        check("coincident_idx", int'(o_step_idx), 0);

        // Disable while held: straight to idle, no load pulse.
        n = m + 21;
        wait_to(n + 1);
        i_hold = 1'b1;
        wait_to(n + 3);
        i_enable = 1'b0;
        wait_to(n + 4);
        check("dis_sw",   int'(o_sw), 0);
        check("dis_idx",  int'(o_step_idx), 0);
        check("dis_busy", int'(o_busy), 0);
        i_hold = 1'b0;

        // Re-enable, run into step 3, then pulse reset between clock edges.
        wait_to(n + 6);
        p = cyc;
        i_enable = 1'b1;
        push(4'b1001, 2'd0, p + 1);
        push(4'b0001, 2'd1, p + 7);
        push(4'b0011, 2'd2, p + 13);
        push(4'b0101, 2'd3, p + 19);
        wait_to(p + 21);
        check("pre_rst_idx", int'(o_step_idx), 3);
        #2;
        i_reset = 1'b0;
        #1;
        check("async_rst_sw",    int'(o_sw), 0);
        check("async_rst_idx",   int'(o_step_idx), 0);
        check("async_rst_busy",  int'(o_busy), 0);
        check("async_rst_valid", int'(o_cfg_valid), 0);
        @(negedge clock);
        @(negedge clock);
        check("in_rst_busy", int'(o_busy), 0);
        r = cyc;
        i_reset = 1'b1;
        push(4'b1001, 2'd0, r + 1);
        push(4'b0001, 2'd1, r + 7);
        wait_to(r + 8);
        i_enable = 1'b0;
        wait_to(r + 9);
        check("final_idle_busy", int'(o_busy), 0);

        // TICK_LIMIT=1, DWELL=1 instance: every running cycle advances.
        check("fast_idle_busy", int'(f_busy), 0);
        f = cyc;
        f_enable = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            wait_to(f + k);
            check("fast_step", int'({f_valid, f_idx, f_sw}),
                  int'({1'b1, 2'(k - 1), fast_sw[k-1]}));
        end
        f_enable = 1'b0;
        wait_to(f + 7);
        check("fast_off_busy", int'(f_busy), 0);

        check("pending_loads", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/led_seq_ctrl.md
LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of the prescaler counter.
REQ-002 Parameter TICK_LIMIT, default 50, clock cycles per tick (>=1).
REQ-003 Parameter DWELL, default 4, ticks spent in each step (>=1).
REQ-004 Port clock  input  1  single clock; all state changes on rising edge.
REQ-005 Port i_reset  input  1  reset, asynchronous, active-low.
REQ-006 Port i_enable  input  1  level; 1 = sequencer running, 0 = return to idle.
REQ-007 Port i_hold  input  1  level; 1 = freeze sequencing, keep current config.
REQ-008 Port i_step  input  1  single-cycle pulse; manual advance to next step.
REQ-009 Port o_sw  output  4  switch configuration driven into the LED datapath.
REQ-010 Port o_step_idx  output  2  current step index.
REQ-011 Port o_cfg_valid  output  1  one-cycle pulse whenever o_sw is loaded with a new step.
REQ-012 Port o_busy  output  1  1 in RUN or HOLD, 0 in IDLE.

Function
REQ-013 All outputs SHALL be registered; response to an input sampled at edge k SHALL be visible after edge k.
REQ-014 FSM states SHALL be IDLE, RUN, HOLD.
REQ-015 Step table SHALL be: step0 4'b1001, step1 4'b0001, step2 4'b0011, step3 4'b0101.
REQ-016 In IDLE, o_sw=4'b0000, o_step_idx=0, prescaler=0, dwell=0, o_busy=0.
REQ-017 IDLE with i_enable=1 SHALL go to RUN, load step0, pulse o_cfg_valid.
REQ-018 In RUN, prescaler SHALL count 0..TICK_LIMIT-1 and wrap to 0; the wrap cycle is a tick.
REQ-019 On a tick, dwell SHALL increment; on a tick with dwell=DWELL-1, dwell clears and the step advances.
REQ-020 Step advance SHALL be index+1 modulo 4 (3 wraps to 0), load the table entry, pulse o_cfg_valid.
REQ-021 i_step in RUN SHALL advance the step immediately and clear prescaler and dwell.
REQ-022 i_step coincident with a dwell-expiry tick SHALL produce exactly one advance.
REQ-023 RUN with i_hold=1 SHALL go to HOLD; prescaler, dwell, o_sw, o_step_idx frozen; i_step ignored.
REQ-024 HOLD with i_hold=0 SHALL return to RUN and resume counting from the frozen values.
REQ-025 i_enable=0 in RUN or HOLD SHALL go to IDLE, overriding i_hold, i_step and ticks.
REQ-026 Priority SHALL be i_enable low > i_hold > i_step > tick.
REQ-027 o_cfg_valid SHALL be 0 on every cycle without a step load, including entry to IDLE and HOLD.
REQ-028 With DWELL=1, every tick SHALL advance; with TICK_LIMIT=1, every RUN cycle is a tick.

Reset
REQ-029 i_reset=0 SHALL asynchronously force IDLE, o_sw=0, o_step_idx=0, o_cfg_valid=0, o_busy=0, counters 0.
REQ-030 Reset asserted mid-RUN or mid-HOLD SHALL discard progress; after release the FSM waits in IDLE for i_enable.
REQ-031 On release, the first edge with i_reset=1 and i_enable=1 SHALL behave per REQ-017.

Verification (TICK_LIMIT=3, DWELL=2)
REQ-032 Reset low, then i_enable=1 -> next edge o_sw=1001, idx=0, o_cfg_valid=1 for one cycle, o_busy=1.
REQ-033 Free run -> step advances every 6 cycles: 0001, 0011, 0101, 1001 (wrap), one valid pulse each.
REQ-034 i_hold=1 for 10 cycles mid-step, then 0 -> o_sw unchanged while held; next advance after the remaining count only.
REQ-035 i_step pulse 2 cycles after a load -> advance next edge; following advance 6 cycles later; i_step on expiry tick -> single advance.
REQ-036 i_enable=0 while i_hold=1 -> IDLE next edge, o_sw=0000, o_busy=0, no valid pulse.
REQ-037 i_reset=0 pulse mid-step3 -> outputs 0 immediately (no clock edge); re-enable restarts at step0.
